glip_loopback_pattern: RTL and testbench
========================================

Name: glip_loopback_pattern

Overview:
Traffic source and sink for the UART GLIP backend, placed directly on the FIFO side of glip_uart_toplevel.
- Generator: drives fifo_out with a wrapping incrementing byte sequence.
- Checker: consumes fifo_in, verifies the host returned an incrementing sequence, and counts good and bad bytes.
- Replaces the fixed-pattern and sink modes of the board demos with a self-checking throughput and integrity test.

Parameters:
WIDTH, 8, data width of both streams
SEED, 0, first value emitted by the generator after reset/clear
CNT_WIDTH, 32, width of the good-byte counter
ERR_WIDTH, 16, width of the error counter
RESYNC_LIMIT, 4, consecutive mismatches that force the checker back to HUNT

Ports:
clk  in  1  single clock (logic clock of the UART backend)
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear of counters, sticky error and generator value
gen_enable  in  1  generator enable
chk_enable  in  1  checker enable (drives in_ready)
out_data  out  WIDTH  generator data to fifo_out_data
out_valid  out  1  generator valid
out_ready  in  1  backend ready
in_data  in  WIDTH  received data from fifo_in_data
in_valid  in  1  received valid
in_ready  out  1  checker ready
locked  out  1  checker in LOCKED state
error  out  1  sticky mismatch flag
err_count  out  ERR_WIDTH  mismatch count, saturating
good_count  out  CNT_WIDTH  matched-byte count, saturating

Behaviour:
- Reset (async assert, sync release by clk):
  - out_valid=0, out_data=SEED, locked=0, error=0, err_count=0, good_count=0.
  - Checker state=HUNT, mismatch run=0.
- Transfer definition: a transfer occurs on a rising edge where valid&ready=1.
- Generator:
  - out_valid and out_data are registers.
  - Idle with gen_enable=1: out_valid rises on the next edge.
  - On each out transfer: out_data <= out_data+1, mod 2^WIDTH (0xFF -> 0x00). out_valid stays 1 while gen_enable=1.
  - Once asserted, out_valid and out_data must not change until a transfer occurs.
  - gen_enable deassert takes effect only after the pending transfer: on that edge out_valid <= 0 and out_data still increments.
  - Full back-to-back throughput: one byte per cycle when out_ready is held high.
- Checker:
  - in_ready = chk_enable, combinational.
  - Holds expected register exp (WIDTH) and mismatch run counter run (width clog2(RESYNC_LIMIT+1)).
  - State HUNT: on in transfer, exp <= in_data+1, run <= 0, go to LOCKED. No counter change.
  - State LOCKED, in transfer with in_data==exp: good_count++ (saturate at all-ones), exp <= exp+1, run <= 0.
  - State LOCKED, in transfer with in_data!=exp:
    - err_count++ (saturate at all-ones), error <= 1, exp <= in_data+1 (resync), run <= run+1.
    - If run+1 == RESYNC_LIMIT: go to HUNT, run <= 0.
  - locked = (state==LOCKED), registered.
- clear (synchronous; takes priority over any simultaneous transfer on the same edge):
  - Counters=0, error=0, state=HUNT, run=0.
  - out_data <= SEED only when no out transfer is pending or a transfer occurs on that edge; the hold rule for a pending valid must never be violated. Otherwise the SEED load is deferred to the next transfer.
- Simultaneous in and out transfers on the same edge are independent and both take effect.
- Reset mid-transfer: all state returns to reset values immediately; the downstream FIFO sees out_valid drop asynchronously.
- No combinational path from out_ready to out_valid/out_data, or from in_valid/in_data to in_ready.

Decomposition:
- Package glip_pattern_pkg:
  - checker state enum (HUNT, LOCKED)
  - saturating-increment helper function
- One natural sub-module: glip_pattern_checker, containing the checker FSM and counters.
- The generator stays inline in glip_loopback_pattern.

Test Plan:
- Gen, out_ready=1, SEED=0, gen_enable=1 for 300 cycles -> out_data sequence 0x00..0xFF, 0x00..0x2B with no gaps; out_valid=1 every cycle after the first.
- Gen backpressure: toggle out_ready randomly; drop gen_enable while out_valid=1 and out_ready=0 -> out_data held stable until accepted, then out_valid=0.
- Checker clean stream: feed 0x10,0x11,...,0x19 -> locked=1 after first byte; good_count=9, err_count=0, error=0.
- Single error: feed 0x05,0x06,0x08,0x09 -> err_count=1, error=1, good_count=2 (0x06 and 0x09), locked stays 1.
- Resync: with RESYNC_LIMIT=4, feed 0x01,0x02 then four bytes 0x50,0x70,0x90,0xB0 (each mismatching the expected value) -> err_count=4, locked=0 after the 4th. Then 0x20,0x21 -> locked=1, good_count=2.
- Clear/reset:
  - Assert clear coincident with an in transfer -> all counters 0, state HUNT.
  - Assert rst asynchronously mid-stream -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/glip_loopback_pattern_pkg.sv
// Shared types and helpers for the GLIP loopback pattern generator/checker.
package glip_pattern_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/glip_loopback_pattern_if.sv
// Valid/ready byte stream between the pattern block and the UART backend FIFOs.
interface glip_loopback_pattern_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glip_pattern_checker.sv
// Incrementing-sequence checker: locks onto the received stream, counts good and bad bytes.
module glip_pattern_checker
    import glip_pattern_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned ERR_WIDTH    = 16,
    parameter int unsigned RESYNC_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 chk_enable_i,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 locked_o,
    output logic                 error_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic [CNT_WIDTH-1:0] good_count_o
);

    localparam int unsigned RUN_W = $clog2(RESYNC_LIMIT + 1);

    chk_state_e           state_q;
    logic [WIDTH-1:0]     exp_q;
    logic [RUN_W-1:0]     run_q;
    logic                 error_q;
    logic [ERR_WIDTH-1:0] err_q;
    logic [CNT_WIDTH-1:0] good_q;

    logic                 in_xfer;
    logic [RUN_W-1:0]     run_d;
    logic [WIDTH-1:0]     resync_d;

    assign in_ready_o = chk_enable_i;
    assign in_xfer    = in_valid_i & chk_enable_i;
    assign run_d      = run_q + RUN_W'(1);
    assign resync_d   = in_data_i + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            exp_q   <= '0;
            run_q   <= '0;
            error_q <= 1'b0;
            err_q   <= '0;
            good_q  <= '0;
        end else if (clear_i) begin
            // Clear wins over a simultaneous transfer; exp is reloaded on the next HUNT hit.
            state_q <= HUNT;
            run_q   <= '0;
            error_q <= 1'b0;
            err_q   <= '0;
            good_q  <= '0;
        end else if (in_xfer) begin
            case (state_q)
                HUNT: begin
                    exp_q   <= resync_d;
                    run_q   <= '0;
                    state_q <= LOCKED;
                end
                LOCKED: begin
                    if (in_data_i == exp_q) begin
                        good_q <= CNT_WIDTH'(sat_inc(64'(good_q), CNT_WIDTH));
                        exp_q  <= exp_q + WIDTH'(1);
                        run_q  <= '0;
                    end else begin
                        err_q   <= ERR_WIDTH'(sat_inc(64'(err_q), ERR_WIDTH));
                        error_q <= 1'b1;
                        exp_q   <= resync_d;
                        if (run_d == RUN_W'(RESYNC_LIMIT)) begin
                            state_q <= HUNT;
                            run_q   <= '0;
                        end else begin
                            run_q <= run_d;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign error_o      = error_q;
    assign err_count_o  = err_q;
    assign good_count_o = good_q;

endmodule

// File: rtl/glip_loopback_pattern.sv
// Loopback traffic source (incrementing bytes) and self-checking sink for the UART GLIP backend.
module glip_loopback_pattern
    import glip_pattern_pkg::*;
#(
    parameter int unsigned     WIDTH        = 8,
    parameter logic [WIDTH-1:0] SEED        = '0,
    parameter int unsigned     CNT_WIDTH    = 32,
    parameter int unsigned     ERR_WIDTH    = 16,
    parameter int unsigned     RESYNC_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    gen_enable,
    input  logic                    chk_enable,
    glip_loopback_pattern_if.master fifo_out,
    glip_loopback_pattern_if.slave  fifo_in,
    output logic                    locked,
    output logic                    error,
    output logic [ERR_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    good_count
);

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             seed_pend_q;
    logic             out_xfer;

    assign out_xfer = out_valid_q & fifo_out.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= SEED;
            out_valid_q <= 1'b0;
            seed_pend_q <= 1'b0;
        end else if (out_xfer) begin
            // A clear seen while a beat was held is applied here, once the beat is accepted.
            out_data_q  <= (clear | seed_pend_q) ? SEED : out_data_q + WIDTH'(1);
            out_valid_q <= gen_enable;
            seed_pend_q <= 1'b0;
        end else if (!out_valid_q) begin
            out_valid_q <= gen_enable;
            if (clear) begin
                out_data_q <= SEED;
            end
        end else if (clear) begin
            seed_pend_q <= 1'b1;
        end
    end

    assign fifo_out.data  = out_data_q;
    assign fifo_out.valid = out_valid_q;

    glip_pattern_checker #(
        .WIDTH        (WIDTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .ERR_WIDTH    (ERR_WIDTH),
        .RESYNC_LIMIT (RESYNC_LIMIT)
    ) u_checker (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .chk_enable_i (chk_enable),
        .in_data_i    (fifo_in.data),
        .in_valid_i   (fifo_in.valid),
        .in_ready_o   (fifo_in.ready),
        .locked_o     (locked),
        .error_o      (error),
        .err_count_o  (err_count),
        .good_count_o (good_count)
    );

endmodule

// File: tb/tb_glip_loopback_pattern.sv
// Scoreboard bench for glip_loopback_pattern: generator sequence/hold rules and checker counters.
module tb_glip_loopback_pattern;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic gen_enable = 1'b0;
    logic chk_enable = 1'b0;
    logic locked, error;
    logic [15:0] err_count;
    logic [31:0] good_count;

    glip_loopback_pattern_if #(.WIDTH(8)) out_if ();
    glip_loopback_pattern_if #(.WIDTH(8)) in_if ();

    glip_loopback_pattern #(
        .WIDTH        (8),
        .SEED         (8'h00),
        .CNT_WIDTH    (32),
        .ERR_WIDTH    (16),
        .RESYNC_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .gen_enable (gen_enable),
        .chk_enable (chk_enable),
        .fifo_out   (out_if),
        .fifo_in    (in_if),
        .locked     (locked),
        .error      (error),
        .err_count  (err_count),
        .good_count (good_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        locked;
        logic        error;
        logic [15:0] err;
        logic [31:0] good;
    } chk_exp_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  gen_q[$];
    chk_exp_t    chk_q[$];

    logic        m_valid;
    logic        hold_pend;
    logic [7:0]  hold_data;
    logic        m_locked;
    logic [7:0]  m_exp;
    int unsigned m_run;
    logic [31:0] m_good;
    logic [15:0] m_err;
    logic        m_error;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        hold_pend = 1'b0;
        hold_data = '0;
        gen_q.delete();
        chk_q.delete();
        m_locked = 1'b0;
        m_exp = '0;
        m_run = 0;
        m_good = '0;
        m_err = '0;
        m_error = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 64'(out_if.valid), 64'd0);
        check_eq({tag, "_out_data"}, 64'(out_if.data), 64'h00);
        check_eq({tag, "_locked"}, 64'(locked), 64'd0);
        check_eq({tag, "_error"}, 64'(error), 64'd0);
        check_eq({tag, "_err_count"}, 64'(err_count), 64'd0);
        check_eq({tag, "_good_count"}, 64'(good_count), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One generator cycle: drive ready/enable/clear for the coming edge, then score what is presented.
    task automatic gen_cycle(input logic rdy, input logic en, input logic clr);
        @(negedge clk);
        out_if.ready = rdy;
        gen_enable = en;
        clear = clr;
        #1;
        check_eq("gen_valid", 64'(out_if.valid), 64'(m_valid));
        if (hold_pend) check_eq("gen_hold", 64'(out_if.data), 64'(hold_data));
        hold_pend = 1'b0;
        if (out_if.valid) begin
            if (rdy) begin
                check_eq("gen_q_avail", 64'(gen_q.size() != 0), 64'd1);
                if (gen_q.size() != 0) check_eq("gen_data", 64'(out_if.data), 64'(gen_q.pop_front()));
            end else begin
                hold_pend = 1'b1;
                hold_data = out_if.data;
            end
        end
        if (!m_valid || rdy) m_valid = en;
    endtask

    task automatic chk_model(input logic [7:0] d, input logic clr);
        chk_exp_t e;
        if (clr) begin
            m_good = '0; m_err = '0; m_error = 1'b0; m_locked = 1'b0; m_run = 0;
        end else if (!m_locked) begin
            m_exp = d + 8'd1; m_run = 0; m_locked = 1'b1;
        end else if (d == m_exp) begin
            if (m_good != '1) m_good = m_good + 32'd1;
            m_exp = d + 8'd1; m_run = 0;
        end else begin
            if (m_err != '1) m_err = m_err + 16'd1;
            m_error = 1'b1; m_exp = d + 8'd1; m_run = m_run + 1;
            if (m_run == 4) begin
                m_locked = 1'b0; m_run = 0;
            end
        end
        e.locked = m_locked; e.error = m_error; e.err = m_err; e.good = m_good;
        chk_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic clr);
        chk_exp_t e;
        @(negedge clk);
        in_if.data = d;
        in_if.valid = 1'b1;
        chk_enable = 1'b1;
        clear = clr;
        chk_model(d, clr);
        @(negedge clk);
        in_if.valid = 1'b0;
        clear = 1'b0;
        #1;
        check_eq("in_ready", 64'(in_if.ready), 64'd1);
        check_eq("chk_q_avail", 64'(chk_q.size() != 0), 64'd1);
        if (chk_q.size() != 0) begin
            e = chk_q.pop_front();
            check_eq("chk_locked", 64'(locked), 64'(e.locked));
            check_eq("chk_error", 64'(error), 64'(e.error));
            check_eq("chk_err_count", 64'(err_count), 64'(e.err));
            check_eq("chk_good_count", 64'(good_count), 64'(e.good));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        out_if.ready = 1'b0;
        in_if.data = '0;
        in_if.valid = 1'b0;
        model_reset();
        do_reset();

        // Free-running generator: 300 bytes, wrapping through 0xFF.
        for (int i = 0; i < 300; i++) gen_q.push_back(8'(i));
        gen_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 299; i++) gen_cycle(1'b1, 1'b1, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);
        check_eq("gen_after_drop_data", 64'(out_if.data), 64'h2C);
        check_eq("gen_q_drained", 64'(gen_q.size()), 64'd0);

        // Random backpressure, then drop enable while a beat is held.
        for (int i = 0; i < 200; i++) gen_q.push_back(8'(8'h2C + i));
        gen_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) gen_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        gen_cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) gen_cycle(1'b0, 1'b0, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);

        // Clear while a beat is held: the held byte goes out unchanged, then SEED follows.
        d = gen_q[0];
        gen_q.delete();
        gen_q.push_back(d);
        gen_q.push_back(8'h00);
        gen_q.push_back(8'h01);
        gen_cycle(1'b0, 1'b1, 1'b0);
        gen_cycle(1'b0, 1'b1, 1'b1);
        gen_cycle(1'b0, 1'b1, 1'b0);
        gen_cycle(1'b1, 1'b1, 1'b0);
        gen_cycle(1'b1, 1'b1, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);
        gen_cycle(1'b1, 1'b0, 1'b0);
        check_eq("gen_seed_next_data", 64'(out_if.data), 64'h02);

        // Checker: clean incrementing stream.
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 1'b0);
        check_eq("clean_good", 64'(good_count), 64'd9);
        check_eq("clean_err", 64'(err_count), 64'd0);
        check_eq("clean_error", 64'(error), 64'd0);
        check_eq("clean_locked", 64'(locked), 64'd1);

        // Checker disabled: no transfer, ready low.
        @(negedge clk);
        chk_enable = 1'b0;
        in_if.data = 8'h77;
        in_if.valid = 1'b1;
        #1 check_eq("disabled_in_ready", 64'(in_if.ready), 64'd0);
        @(negedge clk);
        in_if.valid = 1'b0;
        #1 check_eq("disabled_good", 64'(good_count), 64'd9);

        // Clear coincident with an in transfer, then a single error.
        send_byte(8'h40, 1'b1);
        check_eq("clear_locked", 64'(locked), 64'd0);
        check_eq("clear_good", 64'(good_count), 64'd0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h09, 1'b0);
        check_eq("single_err", 64'(err_count), 64'd1);
        check_eq("single_error", 64'(error), 64'd1);
        check_eq("single_good", 64'(good_count), 64'd2);
        check_eq("single_locked", 64'(locked), 64'd1);

        // Four consecutive mismatches force HUNT.
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h70, 1'b0);
        send_byte(8'h90, 1'b0);
        check_eq("resync_locked_3", 64'(locked), 64'd1);
        send_byte(8'hB0, 1'b0);
        check_eq("resync_err", 64'(err_count), 64'd4);
        check_eq("resync_locked_4", 64'(locked), 64'd0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h21, 1'b0);
        check_eq("relock_locked", 64'(locked), 64'd1);
        check_eq("relock_good", 64'(good_count), 64'd2);

        // Asynchronous reset in the middle of a cycle with the generator streaming.
        @(negedge clk);
        gen_enable = 1'b1;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_eq("pre_rst_valid", 64'(out_if.valid), 64'd1);
        check_eq("pre_rst_locked", 64'(locked), 64'd1);
        rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        gen_enable = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
